// File: rtl/alu_issue_ctrl_pkg.sv
// Shared definitions for the ALU issue controller: ALUop one-hot codes,
// MIPS opcode/funct values, FSM state encoding and immediate-extension helpers.
package alu_issue_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int OP_WIDTH   = 12;

  localparam logic [OP_WIDTH-1:0] ALUOP_ADD  = 12'h001;
  localparam logic [OP_WIDTH-1:0] ALUOP_SUB  = 12'h002;
  localparam logic [OP_WIDTH-1:0] ALUOP_AND  = 12'h004;
  localparam logic [OP_WIDTH-1:0] ALUOP_OR   = 12'h008;
  localparam logic [OP_WIDTH-1:0] ALUOP_NOR  = 12'h010;
  localparam logic [OP_WIDTH-1:0] ALUOP_XOR  = 12'h020;
  localparam logic [OP_WIDTH-1:0] ALUOP_SLT  = 12'h040;
  localparam logic [OP_WIDTH-1:0] ALUOP_SLTU = 12'h080;
  localparam logic [OP_WIDTH-1:0] ALUOP_SLL  = 12'h100;
  localparam logic [OP_WIDTH-1:0] ALUOP_SRL  = 12'h200;
  localparam logic [OP_WIDTH-1:0] ALUOP_SRA  = 12'h400;
  localparam logic [OP_WIDTH-1:0] ALUOP_LUI  = 12'h800;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0a;
  localparam logic [5:0] OPC_SLTIU = 6'h0b;
  localparam logic [5:0] OPC_ANDI  = 6'h0c;
  localparam logic [5:0] OPC_ORI   = 6'h0d;
  localparam logic [5:0] OPC_XORI  = 6'h0e;
  localparam logic [5:0] OPC_LUI   = 6'h0f;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_SRAV = 6'h07;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2a;
  localparam logic [5:0] FN_SLTU = 6'h2b;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [DATA_WIDTH-1:0] signExt16(input logic [15:0] imm);
    return {{(DATA_WIDTH-16){imm[15]}}, imm};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] zeroExt16(input logic [15:0] imm);
    return {{(DATA_WIDTH-16){1'b0}}, imm};
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_op_decode.sv
// Combinational MIPS decoder: maps one instruction plus register operands to
// the one-hot ALUop, the A/B operands, the overflow-trap flag and an illegal flag.
module alu_op_decode
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0]           i_inst,
  input  logic [DATA_WIDTH-1:0] i_rsVal,
  input  logic [DATA_WIDTH-1:0] i_rtVal,
  output logic [OP_WIDTH-1:0]   o_aluOp,
  output logic [DATA_WIDTH-1:0] o_aluA,
  output logic [DATA_WIDTH-1:0] o_aluB,
  output logic                  o_trap,
  output logic                  o_illegal
);

  logic [5:0]  w_opcode;
  logic [5:0]  w_funct;
  logic [4:0]  w_shamt;
  logic [15:0] w_imm;
  logic        w_unusedRegFields;

  assign w_opcode = i_inst[31:26];
  assign w_funct  = i_inst[5:0];
  assign w_shamt  = i_inst[10:6];
  assign w_imm    = i_inst[15:0];
  // Register numbers are resolved upstream; only their values arrive here.
  assign w_unusedRegFields = ^i_inst[25:16];

  // Defaults cover the common A=rs, B=rt form; cases override only what differs.
  always_comb begin
    o_aluOp   = '0;
    o_aluA    = i_rsVal;
    o_aluB    = i_rtVal;
    o_trap    = 1'b0;
    o_illegal = 1'b0;
    case (w_opcode)
      OPC_RTYPE: begin
        case (w_funct)
          FN_ADD:  begin o_aluOp = ALUOP_ADD; o_trap = 1'b1; end
          FN_ADDU: o_aluOp = ALUOP_ADD;
          FN_SUB:  begin o_aluOp = ALUOP_SUB; o_trap = 1'b1; end
          FN_SUBU: o_aluOp = ALUOP_SUB;
          FN_AND:  o_aluOp = ALUOP_AND;
          FN_OR:   o_aluOp = ALUOP_OR;
          FN_XOR:  o_aluOp = ALUOP_XOR;
          FN_NOR:  o_aluOp = ALUOP_NOR;
          FN_SLT:  o_aluOp = ALUOP_SLT;
          FN_SLTU: o_aluOp = ALUOP_SLTU;
          FN_SLL:  begin o_aluOp = ALUOP_SLL; o_aluA = DATA_WIDTH'(w_shamt); end
          FN_SRL:  begin o_aluOp = ALUOP_SRL; o_aluA = DATA_WIDTH'(w_shamt); end
          FN_SRA:  begin o_aluOp = ALUOP_SRA; o_aluA = DATA_WIDTH'(w_shamt); end
          FN_SLLV: o_aluOp = ALUOP_SLL;
          FN_SRLV: o_aluOp = ALUOP_SRL;
          FN_SRAV: o_aluOp = ALUOP_SRA;
          default: o_illegal = 1'b1;
        endcase
      end
      OPC_ADDI:  begin o_aluOp = ALUOP_ADD;  o_aluB = signExt16(w_imm); o_trap = 1'b1; end
      OPC_ADDIU: begin o_aluOp = ALUOP_ADD;  o_aluB = signExt16(w_imm); end
      OPC_SLTI:  begin o_aluOp = ALUOP_SLT;  o_aluB = signExt16(w_imm); end
      OPC_SLTIU: begin o_aluOp = ALUOP_SLTU; o_aluB = signExt16(w_imm); end
      OPC_ANDI:  begin o_aluOp = ALUOP_AND;  o_aluB = zeroExt16(w_imm); end
      OPC_ORI:   begin o_aluOp = ALUOP_OR;   o_aluB = zeroExt16(w_imm); end
      OPC_XORI:  begin o_aluOp = ALUOP_XOR;  o_aluB = zeroExt16(w_imm); end
      OPC_LUI:   begin o_aluOp = ALUOP_LUI;  o_aluA = '0; o_aluB = zeroExt16(w_imm); end
      default:   o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts an instruction over valid/ready, drives the
// external combinational ALU for one cycle, and holds the captured result until consumed.
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           inst,
  input  logic [DATA_WIDTH-1:0] rs_val,
  input  logic [DATA_WIDTH-1:0] rt_val,
  output logic [DATA_WIDTH-1:0] alu_A,
  output logic [DATA_WIDTH-1:0] alu_B,
  output logic [OP_WIDTH-1:0]   alu_op,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic                  alu_overflow,
  input  logic                  alu_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_result,
  output logic                  out_overflow,
  output logic                  out_zero,
  output logic                  out_illegal
);

  logic [OP_WIDTH-1:0]   w_decOp;
  logic [DATA_WIDTH-1:0] w_decA;
  logic [DATA_WIDTH-1:0] w_decB;
  logic                  w_decTrap;
  logic                  w_decIllegal;

  state_t                r_state;
  logic                  r_inReady;
  logic [OP_WIDTH-1:0]   r_aluOp;
  logic [DATA_WIDTH-1:0] r_aluA;
  logic [DATA_WIDTH-1:0] r_aluB;
  logic                  r_trap;
  logic                  r_outValid;
  logic [DATA_WIDTH-1:0] r_outResult;
  logic                  r_outOverflow;
  logic                  r_outZero;
  logic                  r_outIllegal;

  // Decoding straight from the inputs lets the latch store decoded fields, not the raw word.
  alu_op_decode u_decode (
    .i_inst    (inst),
    .i_rsVal   (rs_val),
    .i_rtVal   (rt_val),
    .o_aluOp   (w_decOp),
    .o_aluA    (w_decA),
    .o_aluB    (w_decB),
    .o_trap    (w_decTrap),
    .o_illegal (w_decIllegal)
  );

  // r_aluOp is loaded on entry to EXEC and cleared on leaving it, so it is nonzero only in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_inReady     <= 1'b1;
      r_aluOp       <= '0;
      r_aluA        <= '0;
      r_aluB        <= '0;
      r_trap        <= 1'b0;
      r_outValid    <= 1'b0;
      r_outResult   <= '0;
      r_outOverflow <= 1'b0;
      r_outZero     <= 1'b0;
      r_outIllegal  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_inReady <= 1'b0;
            r_aluA    <= w_decA;
            r_aluB    <= w_decB;
            r_trap    <= w_decTrap;
            if (w_decIllegal) begin
              r_state       <= ST_DONE;
              r_outValid    <= 1'b1;
              r_outResult   <= '0;
              r_outOverflow <= 1'b0;
              r_outZero     <= 1'b0;
              r_outIllegal  <= 1'b1;
            end else begin
              r_state <= ST_EXEC;
              r_aluOp <= w_decOp;
            end
          end
        end
        ST_EXEC: begin
          r_state       <= ST_DONE;
          r_aluOp       <= '0;
          r_outValid    <= 1'b1;
          r_outResult   <= alu_result;
          r_outOverflow <= alu_overflow & r_trap;
          r_outZero     <= alu_zero;
          r_outIllegal  <= 1'b0;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state    <= ST_IDLE;
            r_outValid <= 1'b0;
            r_inReady  <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_inReady <= 1'b1;
          r_aluOp   <= '0;
        end
      endcase
    end
  end

  assign in_ready     = r_inReady;
  assign alu_op       = r_aluOp;
  assign alu_A        = r_aluA;
  assign alu_B        = r_aluB;
  assign out_valid    = r_outValid;
  assign out_result   = r_outResult;
  assign out_overflow = r_outOverflow;
  assign out_zero     = r_outZero;
  assign out_illegal  = r_outIllegal;

endmodule
